// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, reset
// address default and instruction field positions used for pc redirection.
package pc_fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned JIDX_MSB   = 25;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned REGION_MSB = 31;
  localparam int unsigned REGION_LSB = 28;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-pc selection: jump beats taken branch beats sequential.
module next_pc_calc
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] imm_ext;
  logic        unused_opcode;

  // Opcode bits only matter to the decoder, not to target formation.
  assign unused_opcode = ^instruction[31:JIDX_MSB+1];

  assign pc_plus4 = pc + 32'd4;
  assign imm_ext  = {{(XLEN-IMM_W-2){instruction[IMM_MSB]}}, instruction[IMM_MSB:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[REGION_MSB:REGION_LSB], instruction[JIDX_MSB:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + imm_ext;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: requests a word at pc, holds it for the datapath,
// then advances pc on instr_ready using the decoder's branch/jump controls.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic [31:0] retired
);

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;

  next_pc_calc u_next_pc_calc (
    .pc          (pc),
    .instruction (instruction),
    .branch      (Branch),
    .zero        (Zero),
    .jump        (Jump),
    .next_pc     (next_pc),
    .pc_plus4    (pc_plus4)
  );

  assign imem_addr = pc;
  assign link_addr = pc_plus4;

  // Fetch/hold sequencer; control inputs only matter in HOLD with ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instruction <= 32'd0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      retired     <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            state       <= ST_HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            pc          <= next_pc;
            retired     <= retired + 32'd1;
            state       <= ST_FETCH;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: driver pushes expected fetch addresses and
// held-instruction records; a negedge monitor pops and compares them.
module tb_pc_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic        Jump = 1'b0;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic [31:0] retired;

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .Branch      (Branch),
    .Zero        (Zero),
    .Jump        (Jump),
    .pc          (pc),
    .link_addr   (link_addr),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] link;
    logic [31:0] retired;
  } hold_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fetch_q[$];
  hold_t       hold_q[$];
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_retired = 32'd0;
  bit          mon_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next-pc from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input bit b, input bit z, input bit j);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = $signed(ins[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  // Monitor: compares new fetches and new held instructions against the queues.
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] cur_addr = 32'd0;
  logic [31:0] cur_instr = 32'd0;

  always @(negedge clk) begin
    if (mon_en) begin
      check32("req_valid_exclusive", 32'(imem_req & instr_valid), 32'd0);
      if (imem_req) begin
        if (!prev_req) begin
          if (fetch_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_fetch actual=%h required=none", imem_addr);
          end else begin
            cur_addr = fetch_q.pop_front();
            check32("fetch_addr", imem_addr, cur_addr);
          end
        end else begin
          check32("fetch_addr_stable", imem_addr, cur_addr);
        end
      end
      if (instr_valid) begin
        if (!prev_valid) begin
          if (hold_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid actual=%h required=none", instruction);
          end else begin
            hold_t h;
            h = hold_q.pop_front();
            cur_instr = h.instr;
            check32("held_instr", instruction, h.instr);
            check32("held_pc", pc, h.pc);
            check32("link_addr", link_addr, h.link);
            check32("retired", retired, h.retired);
          end
        end else begin
          check32("instr_stable", instruction, cur_instr);
        end
      end
      prev_req   = imem_req;
      prev_valid = instr_valid;
    end
  end

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check32("rst_imem_req", 32'(imem_req), 32'd0);
    check32("rst_instr_valid", 32'(instr_valid), 32'd0);
    check32("rst_pc", pc, RST_PC);
    check32("rst_instruction", instruction, 32'd0);
    check32("rst_retired", retired, 32'd0);
    check32("rst_link_addr", link_addr, RST_PC + 32'd4);
    m_pc = RST_PC;
    m_retired = 32'd0;
    fetch_q.push_back(m_pc);
    mon_en = 1'b1;
    rst = 1'b0;
  endtask

  // One fetch/hold/retire transaction; starts and ends at a negedge.
  task automatic run_txn(input logic [31:0] ins, input bit b, input bit z, input bit j,
                         input int stall, input int hold);
    int cnt = 0;
    while (!imem_req && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!imem_req) begin
      checks++; errors++;
      $display("FAIL fetch_timeout actual=no_req required=req");
      return;
    end
    repeat (stall) begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      Branch = 1'($urandom); Zero = 1'($urandom); Jump = 1'($urandom);
      @(negedge clk);
    end
    imem_ack = 1'b1; imem_rdata = ins;
    hold_q.push_back('{ins, m_pc, m_pc + 32'd4, m_retired});
    @(negedge clk);
    imem_ack = 1'b0;
    check32("ack_to_valid_latency", 32'(instr_valid), 32'd1);
    repeat (hold) begin
      instr_ready = 1'b0;
      Branch = 1'($urandom); Zero = 1'($urandom); Jump = 1'($urandom);
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      @(negedge clk);
    end
    instr_ready = 1'b1; Branch = b; Zero = z; Jump = j;
    imem_ack = 1'($urandom); imem_rdata = $urandom;
    m_pc = model_next(m_pc, ins, b, z, j);
    m_retired = m_retired + 32'd1;
    fetch_q.push_back(m_pc);
    @(negedge clk);
    instr_ready = 1'b0; imem_ack = 1'b0;
    Branch = 1'($urandom); Zero = 1'($urandom); Jump = 1'($urandom);
    check32("ready_to_req_latency", 32'(imem_req), 32'd1);
  endtask

  initial begin
    do_reset();
    run_txn(32'h2008_0005, 1'b0, 1'b0, 1'b0, 0, 0);  // 3000 -> 3004
    run_txn(32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 3, 1);  // 3004 -> 3000, stalled fetch
    run_txn(32'h0000_0020, 1'b0, 1'b0, 1'b0, 0, 0);  // 3000 -> 3004
    run_txn(32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1, 2);  // 3004 -> 3008, not taken
    run_txn($urandom, 1'b0, 1'b0, 1'b0, 0, 0);        // -> 300C
    run_txn($urandom, 1'b0, 1'b0, 1'b0, 1, 0);        // -> 3010
    run_txn(32'h0800_0C10, 1'b1, 1'b1, 1'b1, 0, 1);  // 3010 -> 3040, jump wins
    run_txn(32'h1000_F3EE, 1'b1, 1'b1, 1'b0, 0, 0);  // 3040 -> FFFFFFFC
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    m_retired = 32'hFFFF_FFFF;
    run_txn(32'h0000_0001, 1'b0, 1'b0, 1'b0, 0, 0);  // FFFFFFFC -> 0, retired wraps
    for (int i = 0; i < 40; i++) begin
      run_txn($urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    run_txn(32'h1234_5678, 1'b0, 1'b0, 1'b0, 0, 0);
    // Reset collides with an ack in FETCH: data must be dropped.
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    check32("rst_ack_instr_valid", 32'(instr_valid), 32'd0);
    check32("rst_ack_imem_req", 32'(imem_req), 32'd0);
    check32("rst_ack_pc", pc, RST_PC);
    check32("rst_ack_instruction", instruction, 32'd0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_txn($urandom, 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    repeat (2) @(negedge clk);
    check32("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    check32("hold_q_drained", 32'(hold_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
